// File: rtl/core_mem_if.sv
// EX/MEM, data bus and MEM/WB bundles for the memory stage.
// Handshake rule shared by all three bundles: a transfer happens on a rising
// clock edge where valid and ready are both 1; the master keeps valid and all
// payload stable until that edge, and ready may not depend on future valid.

interface em_if;
  logic        em_valid;
  logic        em_ready;
  logic [31:0] em_reg_data_mem_addr;
  logic [31:0] em_csr_data_mem_data;
  logic        em_mem_read;
  logic        em_mem_write;
  logic [2:0]  em_mem_op;
  logic [4:0]  em_rd;
  logic        em_reg_write;
  logic [11:0] em_csr;
  logic        em_csr_write;

  modport master (
    output em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
           em_mem_write, em_mem_op, em_rd, em_reg_write, em_csr, em_csr_write,
    input  em_ready
  );
  modport slave (
    input  em_valid, em_reg_data_mem_addr, em_csr_data_mem_data, em_mem_read,
           em_mem_write, em_mem_op, em_rd, em_reg_write, em_csr, em_csr_write,
    output em_ready
  );
endinterface

interface dbus_if;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    input  mem_req_ready, mem_rsp_valid, mem_rdata
  );
  modport slave (
    input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
    output mem_req_ready, mem_rsp_valid, mem_rdata
  );
endinterface

interface mw_if;
  logic        mw_valid;
  logic        mw_ready;
  logic [4:0]  mw_rd;
  logic        mw_reg_write;
  logic [31:0] mw_reg_data;
  logic [11:0] mw_csr;
  logic        mw_csr_write;
  logic [31:0] mw_csr_data;
  logic        mw_exc;
  logic [3:0]  mw_exc_cause;
  logic [31:0] mw_exc_tval;

  modport master (
    output mw_valid, mw_rd, mw_reg_write, mw_reg_data, mw_csr, mw_csr_write,
           mw_csr_data, mw_exc, mw_exc_cause, mw_exc_tval,
    input  mw_ready
  );
  modport slave (
    input  mw_valid, mw_rd, mw_reg_write, mw_reg_data, mw_csr, mw_csr_write,
           mw_csr_data, mw_exc, mw_exc_cause, mw_exc_tval,
    output mw_ready
  );
endinterface

// File: rtl/core_mem.sv
// RISC-V memory stage. Takes one EX/MEM entry at a time, performs the data
// bus access for aligned loads/stores, aligns/extends load data and presents
// the result (or a misalign/timeout exception) in a single MEM/WB register.

module core_mem #(
  parameter int BUS_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rest,
  em_if.slave        em,
  dbus_if.master     bus,
  mw_if.master       mw,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(BUS_TIMEOUT - 1);

  state_t      state, state_nx;
  logic [15:0] tmo_cnt;

  // Captured entry for the bus access in flight
  logic [31:0] cap_addr;
  logic [31:0] cap_data;
  logic        cap_read;
  logic [2:0]  cap_op;
  logic [4:0]  cap_rd;
  logic        cap_reg_write;
  logic [11:0] cap_csr;
  logic        cap_csr_write;
  logic        cap_we;
  logic [3:0]  cap_wstrb;
  logic [31:0] cap_wdata;

  // MEM/WB register
  logic        mw_valid_q;
  logic [4:0]  mw_rd_q;
  logic        mw_reg_write_q;
  logic [31:0] mw_reg_data_q;
  logic [11:0] mw_csr_q;
  logic        mw_csr_write_q;
  logic [31:0] mw_csr_data_q;
  logic        mw_exc_q;
  logic [3:0]  mw_exc_cause_q;
  logic [31:0] mw_exc_tval_q;

  logic accept, is_mem, misaligned, go_bus, direct;
  logic rsp_hit, timeout, finish_bus, mw_load;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  logic [4:0]  nx_rd;
  logic        nx_reg_write;
  logic [31:0] nx_reg_data;
  logic [11:0] nx_csr;
  logic        nx_csr_write;
  logic [31:0] nx_csr_data;
  logic        nx_exc;
  logic [3:0]  nx_exc_cause;
  logic [31:0] nx_exc_tval;

  assign em.em_ready = rest && (state == IDLE) && (!mw_valid_q || mw.mw_ready);
  assign accept      = em.em_valid && em.em_ready;
  assign is_mem      = em.em_mem_read || em.em_mem_write;
  // Half needs addr[0]==0; word (op[1] set) needs addr[1:0]==0
  assign misaligned  = ((em.em_mem_op[1:0] == 2'b01) && em.em_reg_data_mem_addr[0]) ||
                       (em.em_mem_op[1] && (em.em_reg_data_mem_addr[1:0] != 2'b00));
  assign go_bus      = accept && is_mem && !misaligned;
  assign direct      = accept && !(is_mem && !misaligned);

  assign rsp_hit     = (state == WAIT_RSP) && bus.mem_rsp_valid;
  assign timeout     = (state == WAIT_RSP) && !bus.mem_rsp_valid && (tmo_cnt == TMO_LAST);
  assign finish_bus  = rsp_hit || timeout;
  assign mw_load     = direct || finish_bus;

  assign bus.mem_req_valid = (state == REQ);
  assign bus.mem_addr      = {cap_addr[31:2], 2'b00};
  assign bus.mem_we        = cap_we;
  assign bus.mem_wstrb     = cap_wstrb;
  assign bus.mem_wdata     = cap_wdata;

  assign mw.mw_valid     = mw_valid_q;
  assign mw.mw_rd        = mw_rd_q;
  assign mw.mw_reg_write = mw_reg_write_q;
  assign mw.mw_reg_data  = mw_reg_data_q;
  assign mw.mw_csr       = mw_csr_q;
  assign mw.mw_csr_write = mw_csr_write_q;
  assign mw.mw_csr_data  = mw_csr_data_q;
  assign mw.mw_exc       = mw_exc_q;
  assign mw.mw_exc_cause = mw_exc_cause_q;
  assign mw.mw_exc_tval  = mw_exc_tval_q;

  assign dbg_state = state;

  // State register
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: one bus access per aligned memory entry, never cancelled
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (go_bus)            state_nx = REQ;
      REQ:      if (bus.mem_req_ready) state_nx = WAIT_RSP;
      WAIT_RSP: if (finish_bus)        state_nx = IDLE;
      default:                         state_nx = IDLE;
    endcase
  end

  // Response timeout counter: runs only while waiting for a response
  always_ff @(posedge clk or negedge rest) begin
    if (!rest)                  tmo_cnt <= 16'd0;
    else if (state != WAIT_RSP) tmo_cnt <= 16'd0;
    else                        tmo_cnt <= tmo_cnt + 16'd1;
  end

  // Store lane encoding from the incoming entry
  always_comb begin
    st_strb  = 4'h0;
    st_wdata = 32'h0;
    if (em.em_mem_write) begin
      case (em.em_mem_op[1:0])
        2'b00: begin
          st_strb  = 4'b0001 << em.em_reg_data_mem_addr[1:0];
          st_wdata = {4{em.em_csr_data_mem_data[7:0]}};
        end
        2'b01: begin
          st_strb  = em.em_reg_data_mem_addr[1] ? 4'b1100 : 4'b0011;
          st_wdata = {2{em.em_csr_data_mem_data[15:0]}};
        end
        default: begin
          st_strb  = 4'hF;
          st_wdata = em.em_csr_data_mem_data;
        end
      endcase
    end
  end

  // Capture the entry and its bus payload when a bus access starts
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      cap_addr      <= 32'h0;
      cap_data      <= 32'h0;
      cap_read      <= 1'b0;
      cap_op        <= 3'd0;
      cap_rd        <= 5'd0;
      cap_reg_write <= 1'b0;
      cap_csr       <= 12'h0;
      cap_csr_write <= 1'b0;
      cap_we        <= 1'b0;
      cap_wstrb     <= 4'h0;
      cap_wdata     <= 32'h0;
    end else if (go_bus) begin
      cap_addr      <= em.em_reg_data_mem_addr;
      cap_data      <= em.em_csr_data_mem_data;
      cap_read      <= em.em_mem_read;
      cap_op        <= em.em_mem_op;
      cap_rd        <= em.em_rd;
      cap_reg_write <= em.em_reg_write;
      cap_csr       <= em.em_csr;
      cap_csr_write <= em.em_csr_write;
      cap_we        <= em.em_mem_write;
      cap_wstrb     <= st_strb;
      cap_wdata     <= st_wdata;
    end
  end

  // Load data alignment and sign/zero extension
  always_comb begin
    case (cap_addr[1:0])
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = cap_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (cap_op)
      3'd0:    ld_result = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_result = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_result = {24'h0, ld_byte};
      3'd5:    ld_result = {16'h0, ld_half};
      default: ld_result = bus.mem_rdata;
    endcase
  end

  // Next MEM/WB contents: bus completion or a direct (non-bus) entry
  always_comb begin
    nx_rd        = em.em_rd;
    nx_reg_write = em.em_reg_write;
    nx_reg_data  = em.em_reg_data_mem_addr;
    nx_csr       = em.em_csr;
    nx_csr_write = em.em_csr_write;
    nx_csr_data  = em.em_csr_data_mem_data;
    nx_exc       = 1'b0;
    nx_exc_cause = 4'd0;
    nx_exc_tval  = 32'h0;
    if (finish_bus) begin
      nx_rd        = cap_rd;
      nx_reg_write = cap_read && cap_reg_write && !timeout;
      nx_reg_data  = cap_read ? ld_result : cap_addr;
      nx_csr       = cap_csr;
      nx_csr_write = cap_csr_write && !timeout;
      nx_csr_data  = cap_data;
      if (timeout) begin
        nx_exc       = 1'b1;
        nx_exc_cause = cap_read ? 4'd5 : 4'd7;
        nx_exc_tval  = cap_addr;
      end
    end else if (is_mem) begin
      // A direct memory entry is always a misaligned one
      nx_exc       = 1'b1;
      nx_exc_cause = em.em_mem_read ? 4'd4 : 4'd6;
      nx_exc_tval  = em.em_reg_data_mem_addr;
      nx_reg_write = 1'b0;
      nx_csr_write = 1'b0;
    end
  end

  // MEM/WB register: load replaces (even while draining), else drain on ready
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      mw_valid_q     <= 1'b0;
      mw_rd_q        <= 5'd0;
      mw_reg_write_q <= 1'b0;
      mw_reg_data_q  <= 32'h0;
      mw_csr_q       <= 12'h0;
      mw_csr_write_q <= 1'b0;
      mw_csr_data_q  <= 32'h0;
      mw_exc_q       <= 1'b0;
      mw_exc_cause_q <= 4'd0;
      mw_exc_tval_q  <= 32'h0;
    end else if (mw_load) begin
      mw_valid_q     <= 1'b1;
      mw_rd_q        <= nx_rd;
      mw_reg_write_q <= nx_reg_write;
      mw_reg_data_q  <= nx_reg_data;
      mw_csr_q       <= nx_csr;
      mw_csr_write_q <= nx_csr_write;
      mw_csr_data_q  <= nx_csr_data;
      mw_exc_q       <= nx_exc;
      mw_exc_cause_q <= nx_exc_cause;
      mw_exc_tval_q  <= nx_exc_tval;
    end else if (mw.mw_ready) begin
      mw_valid_q     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_core_mem.sv
// Bench for core_mem: table of entries with expected MEM/WB results pushed
// to a scoreboard, a monitor popping on MEM/WB handshakes, and hand-written
// sequences for timeout, late response, backpressure and mid-access reset.

module tb_core_mem;

  logic       clk = 1'b0;
  logic       rest = 1'b0;
  logic [1:0] dbg_state;

  em_if   em();
  dbus_if bus();
  mw_if   mw();

  core_mem #(.BUS_TIMEOUT(4)) dut (
    .clk       (clk),
    .rest      (rest),
    .em        (em.slave),
    .bus       (bus.master),
    .mw        (mw.master),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        ld;
    logic        st;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [11:0] csr;
    logic        csrw;
    logic [31:0] rdata;
    int          req_delay;
    logic [31:0] exp_data;
    logic        exp_exc;
    logic [3:0]  exp_cause;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  logic [119:0] exp_q[$];
  logic [119:0] msk_q[$];
  vec_t         vecs[16];

  function automatic logic [119:0] pk(logic [4:0] rd, logic rw, logic [31:0] rdat,
                                      logic [11:0] csr, logic csrw, logic [31:0] csrd,
                                      logic exc, logic [3:0] cause, logic [31:0] tval);
    return {rd, rw, rdat, csr, csrw, csrd, exc, cause, tval};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard push: expected MEM/WB entry and care mask for one entry
  task automatic expect_push(input vec_t v);
    logic [119:0] e, m;
    e = pk(v.rd, (v.exp_exc || v.st) ? 1'b0 : v.rw, v.exp_data, v.csr,
           v.exp_exc ? 1'b0 : v.csrw, v.data, v.exp_exc, v.exp_cause,
           v.exp_exc ? v.addr : 32'h0);
    m = pk(5'h1F, 1'b1, (v.st || v.exp_exc) ? 32'h0 : 32'hFFFF_FFFF, 12'hFFF, 1'b1,
           32'hFFFF_FFFF, 1'b1, v.exp_exc ? 4'hF : 4'h0,
           v.exp_exc ? 32'hFFFF_FFFF : 32'h0);
    exp_q.push_back(e);
    msk_q.push_back(m);
  endtask

  // Monitor: compare every entry WB takes against the scoreboard
  initial begin
    logic [119:0] a, e, m;
    forever begin
      @(negedge clk);
      if (rest && mw.mw_valid && mw.mw_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL mw_unexpected: got entry rd=%0d data=%h with empty queue",
                   mw.mw_rd, mw.mw_reg_data);
        end else begin
          a = pk(mw.mw_rd, mw.mw_reg_write, mw.mw_reg_data, mw.mw_csr, mw.mw_csr_write,
                 mw.mw_csr_data, mw.mw_exc, mw.mw_exc_cause, mw.mw_exc_tval);
          e = exp_q.pop_front();
          m = msk_q.pop_front();
          if ((a & m) !== (e & m)) begin
            n_errors++;
            $display("FAIL mw_entry: got %h expected %h (mask %h)", a, e, m);
          end
        end
      end
    end
  end

  // Driver: present one entry and hold it until accepted (bounded)
  task automatic send(input vec_t v);
    int n;
    em.em_valid             = 1'b1;
    em.em_reg_data_mem_addr = v.addr;
    em.em_csr_data_mem_data = v.data;
    em.em_mem_read          = v.ld;
    em.em_mem_write         = v.st;
    em.em_mem_op            = v.op;
    em.em_rd                = v.rd;
    em.em_reg_write         = v.rw;
    em.em_csr               = v.csr;
    em.em_csr_write         = v.csrw;
    n = 0;
    @(negedge clk);
    while (!em.em_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {31'h0, em.em_ready}, 32'h1);
    @(posedge clk); #1;
    em.em_valid = 1'b0;
  endtask

  // Driver: serve the bus request of entry v (called right after accept)
  task automatic bus_serve(input vec_t v);
    logic [69:0] exp_bus;
    exp_bus = {1'b1, v.addr[31:2], 2'b00, v.st, v.st ? v.exp_strb : 4'h0,
               v.st ? v.exp_wdata : 32'h0};
    chk("req_valid", {31'h0, bus.mem_req_valid}, 32'h1);
    chk("req_addr", bus.mem_addr, {v.addr[31:2], 2'b00});
    chk("req_we", {31'h0, bus.mem_we}, {31'h0, v.st});
    if (v.st) begin
      chk("req_wstrb", {28'h0, bus.mem_wstrb}, {28'h0, v.exp_strb});
      chk("req_wdata", bus.mem_wdata, v.exp_wdata);
    end
    for (int i = 0; i < v.req_delay; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus.mem_req_valid, bus.mem_addr, bus.mem_we,
           v.st ? bus.mem_wstrb : 4'h0, v.st ? bus.mem_wdata : 32'h0} !== exp_bus) begin
        n_errors++;
        $display("FAIL req_stable: got addr=%h we=%b strb=%h wdata=%h valid=%b",
                 bus.mem_addr, bus.mem_we, bus.mem_wstrb, bus.mem_wdata, bus.mem_req_valid);
      end
    end
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = v.rdata;
    chk("rsp_not_early", {31'h0, mw.mw_valid}, 32'h0);
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rdata     = 32'h0;
    chk("rsp_latency", {31'h0, mw.mw_valid}, 32'h1);
  endtask

  initial begin
    vec_t v;
    // addr, data, ld, st, op, rd, rw, csr, csrw, rdata, req_delay, exp_data, exc, cause, strb, wdata
    vecs[0]  = '{32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b1, 12'h000, 1'b0, 32'h0, 0,
                 32'h0000_1234, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[1]  = '{32'h0000_00AA, 32'hDEAD_BEEF, 1'b0, 1'b0, 3'd0, 5'd7, 1'b1, 12'h300, 1'b1, 32'h0, 0,
                 32'h0000_00AA, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[2]  = '{32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'd0, 5'd1, 1'b1, 12'h000, 1'b0, 32'h80FF_0000, 0,
                 32'hFFFF_FF80, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[3]  = '{32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'd4, 5'd2, 1'b1, 12'h000, 1'b0, 32'h80FF_0000, 0,
                 32'h0000_0080, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[4]  = '{32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'd1, 5'd3, 1'b1, 12'h000, 1'b0, 32'h8001_1234, 0,
                 32'hFFFF_8001, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[5]  = '{32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'd5, 5'd4, 1'b1, 12'h000, 1'b0, 32'h8001_F234, 0,
                 32'h0000_F234, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[6]  = '{32'h0000_0104, 32'h0, 1'b1, 1'b0, 3'd2, 5'd6, 1'b1, 12'h000, 1'b0, 32'hCAFE_BABE, 1,
                 32'hCAFE_BABE, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[7]  = '{32'h0000_0101, 32'h0, 1'b1, 1'b0, 3'd0, 5'd8, 1'b1, 12'h000, 1'b0, 32'h0000_7F00, 0,
                 32'h0000_007F, 1'b0, 4'd0, 4'h0, 32'h0};
    vecs[8]  = '{32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 3'd1, 5'd9, 1'b1, 12'h000, 1'b0, 32'h0, 3,
                 32'h0, 1'b0, 4'd0, 4'b1100, 32'hABCD_ABCD};
    vecs[9]  = '{32'h0000_0301, 32'h1234_5678, 1'b0, 1'b1, 3'd0, 5'd0, 1'b0, 12'h000, 1'b0, 32'h0, 0,
                 32'h0, 1'b0, 4'd0, 4'b0010, 32'h7878_7878};
    vecs[10] = '{32'h0000_0400, 32'h1122_3344, 1'b0, 1'b1, 3'd2, 5'd0, 1'b0, 12'h000, 1'b0, 32'h0, 2,
                 32'h0, 1'b0, 4'd0, 4'hF, 32'h1122_3344};
    vecs[11] = '{32'h0000_0001, 32'h0, 1'b1, 1'b0, 3'd2, 5'd10, 1'b1, 12'h000, 1'b0, 32'h0, 0,
                 32'h0, 1'b1, 4'd4, 4'h0, 32'h0};
    vecs[12] = '{32'h0000_0002, 32'h5555_AAAA, 1'b0, 1'b1, 3'd2, 5'd0, 1'b0, 12'h000, 1'b0, 32'h0, 0,
                 32'h0, 1'b1, 4'd6, 4'h0, 32'h0};
    vecs[13] = '{32'h0000_0103, 32'h0, 1'b1, 1'b0, 3'd1, 5'd11, 1'b1, 12'h000, 1'b0, 32'h0, 0,
                 32'h0, 1'b1, 4'd4, 4'h0, 32'h0};
    vecs[14] = '{32'h0000_0001, 32'h0000_0011, 1'b0, 1'b1, 3'd1, 5'd0, 1'b0, 12'h000, 1'b0, 32'h0, 0,
                 32'h0, 1'b1, 4'd6, 4'h0, 32'h0};
    vecs[15] = '{32'h0000_0003, 32'h0, 1'b1, 1'b0, 3'd5, 5'd12, 1'b1, 12'h341, 1'b1, 32'h0, 0,
                 32'h0, 1'b1, 4'd4, 4'h0, 32'h0};

    // Reset
    em.em_valid = 1'b0; em.em_reg_data_mem_addr = 32'h0; em.em_csr_data_mem_data = 32'h0;
    em.em_mem_read = 1'b0; em.em_mem_write = 1'b0; em.em_mem_op = 3'd0; em.em_rd = 5'd0;
    em.em_reg_write = 1'b0; em.em_csr = 12'h0; em.em_csr_write = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rdata = 32'h0;
    mw.mw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_em_ready", {31'h0, em.em_ready}, 32'h0);
    chk("rst_state", {30'h0, dbg_state}, 32'h0);
    chk("rst_req_valid", {31'h0, bus.mem_req_valid}, 32'h0);
    chk("rst_mw_valid", {31'h0, mw.mw_valid}, 32'h0);
    chk("rst_mw_data", mw.mw_reg_data | mw.mw_csr_data | mw.mw_exc_tval, 32'h0);
    @(negedge clk);
    rest = 1'b1;
    @(posedge clk); #1;

    // Table of single entries
    for (int i = 0; i < 16; i++) begin
      v = vecs[i];
      expect_push(v);
      send(v);
      if ((v.ld || v.st) && !v.exp_exc) begin
        bus_serve(v);
      end else begin
        chk($sformatf("direct_valid_%0d", i), {31'h0, mw.mw_valid}, 32'h1);
        chk($sformatf("direct_nobus_%0d", i), {31'h0, bus.mem_req_valid}, 32'h0);
      end
      @(posedge clk); #1;
    end

    // Load timeout: fault 4 cycles after request accept, then a late response
    v = '{32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'd2, 5'd13, 1'b1, 12'h000, 1'b0, 32'h0, 0,
          32'h0, 1'b1, 4'd5, 4'h0, 32'h0};
    expect_push(v);
    send(v);
    chk("tmo_req", {31'h0, bus.mem_req_valid}, 32'h1);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("tmo_not_early", {31'h0, mw.mw_valid}, 32'h0);
    @(posedge clk); #1;
    chk("tmo_fault", {31'h0, mw.mw_valid}, 32'h1);
    chk("tmo_idle", {30'h0, dbg_state}, 32'h0);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rdata     = 32'h1357_9BDF;
    @(posedge clk); #1;
    bus.mem_rsp_valid = 1'b0;
    chk("late_rsp_ignored", {31'h0, mw.mw_valid}, 32'h0);
    chk("late_rsp_state", {30'h0, dbg_state}, 32'h0);

    // Store timeout
    v = '{32'h0000_0504, 32'h0BAD_F00D, 1'b0, 1'b1, 3'd2, 5'd0, 1'b0, 12'h000, 1'b0, 32'h0, 0,
          32'h0, 1'b1, 4'd7, 4'h0, 32'h0};
    expect_push(v);
    send(v);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("st_tmo_fault", {31'h0, mw.mw_valid}, 32'h1);
    @(posedge clk); #1;

    // Backpressure: entry held, em_ready low, then replacement without bubble
    mw.mw_ready = 1'b0;
    v = vecs[0];
    v.addr = 32'h0000_AAAA; v.exp_data = 32'h0000_AAAA;
    expect_push(v);
    send(v);
    v.addr = 32'h0000_BBBB; v.exp_data = 32'h0000_BBBB; v.rd = 5'd17;
    expect_push(v);
    em.em_valid = 1'b1; em.em_reg_data_mem_addr = v.addr; em.em_csr_data_mem_data = v.data;
    em.em_mem_read = 1'b0; em.em_mem_write = 1'b0; em.em_mem_op = 3'd0; em.em_rd = v.rd;
    em.em_reg_write = 1'b1; em.em_csr = 12'h0; em.em_csr_write = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_em_ready", {31'h0, em.em_ready}, 32'h0);
      chk("bp_hold", mw.mw_reg_data, 32'h0000_AAAA);
    end
    @(posedge clk); #1;
    mw.mw_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", {31'h0, em.em_ready}, 32'h1);
    @(posedge clk); #1;
    em.em_valid = 1'b0;
    chk("bp_nobubble_valid", {31'h0, mw.mw_valid}, 32'h1);
    chk("bp_nobubble_data", mw.mw_reg_data, 32'h0000_BBBB);
    @(posedge clk); #1;

    // Reset in WAIT_RSP abandons the access
    v = vecs[6];
    send(v);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_wait_state", {30'h0, dbg_state}, 32'd2);
    rest = 1'b0;
    #1;
    chk("mid_rst_state", {30'h0, dbg_state}, 32'h0);
    chk("mid_rst_em_ready", {31'h0, em.em_ready}, 32'h0);
    chk("mid_rst_bus", {31'h0, bus.mem_req_valid} | bus.mem_addr | bus.mem_wdata, 32'h0);
    chk("mid_rst_mw", {31'h0, mw.mw_valid} | mw.mw_reg_data | mw.mw_csr_data |
                      {27'h0, mw.mw_rd}, 32'h0);
    @(negedge clk);
    rest = 1'b1;
    @(posedge clk); #1;
    v = vecs[1];
    expect_push(v);
    send(v);
    chk("post_rst_valid", {31'h0, mw.mw_valid}, 32'h1);
    repeat (2) @(posedge clk);
    #1;

    chk("queue_empty", exp_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
